// File: rtl/bubble_in_capture_if.sv
// Host-side capture and SPI-side drain signals of the bubble input capture buffer.
// The design sits on the slave modport; the driving environment uses master.
interface bubble_in_capture_if;
    logic        BITWIDTH4;
    logic [2:0]  ACCTYPE;
    logic [12:0] BINCYCLENUM;
    logic        nBINCLKEN;
    logic        DIN0;
    logic        DIN1;
    logic        DIN2;
    logic        DIN3;
    logic        DRAINSTART;
    logic        nINBUFRDCLKEN;
    logic        INBUFRDDATA;
    logic [11:0] INBUFRDADDR;
    logic        INBUFRDLAST;
    logic        PAGEVALID;
    logic        CAPERR;

    modport master (
        output BITWIDTH4, ACCTYPE, BINCYCLENUM, nBINCLKEN,
        output DIN0, DIN1, DIN2, DIN3, DRAINSTART, nINBUFRDCLKEN,
        input  INBUFRDDATA, INBUFRDADDR, INBUFRDLAST, PAGEVALID, CAPERR
    );

    modport slave (
        input  BITWIDTH4, ACCTYPE, BINCYCLENUM, nBINCLKEN,
        input  DIN0, DIN1, DIN2, DIN3, DRAINSTART, nINBUFRDCLKEN,
        output INBUFRDDATA, INBUFRDADDR, INBUFRDLAST, PAGEVALID, CAPERR
    );
endinterface

// File: rtl/bubble_in_capture.sv
// Captures one user page of bubble input bits into a 4-channel buffer, then
// replays it as an interleaved serial stream for the flash write-back path.
module bubble_in_capture #(
    parameter int PAGEBITS = 584,
    parameter int BUFDEPTH = 1024
) (
    input  logic                MCLK,
    input  logic                nRESET,
    bubble_in_capture_if.slave  bus
);

    localparam int AW = $clog2(BUFDEPTH);
    localparam logic [11:0] LAST_IDX_2 = 12'(2 * PAGEBITS - 1);
    localparam logic [11:0] LAST_IDX_4 = 12'(4 * PAGEBITS - 1);
    localparam logic [2:0]  ACC_USER_WR = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        READY,
        DRAIN
    } state_t;

    state_t      r_state;
    logic        r_width4;
    logic        r_got;
    logic [11:0] r_idx;
    logic        r_rd_data;
    logic [11:0] r_rd_addr;
    logic        r_rd_last;
    logic        r_page_valid;
    logic        r_cap_err;

    logic r_mem [4][BUFDEPTH];

    logic          w_acc_wr;
    logic          w_cap_start;
    logic          w_capturing;
    logic          w_width4;
    logic [AW-1:0] w_wr_addr;
    logic          w_in_range;
    logic          w_wr_en;
    logic [AW-1:0] w_rd_cyc;
    logic [1:0]    w_rd_ch;
    logic [11:0]   w_last_idx;
    logic          w_strobe;
    logic          w_unused_cyc_hi;

    assign w_acc_wr    = (bus.ACCTYPE == ACC_USER_WR);
    assign w_cap_start = (r_state == IDLE) && w_acc_wr;
    assign w_capturing = w_cap_start || (r_state == CAPTURE);

    // Width is taken live on the start cycle so a tick coinciding with it uses the new mode.
    assign w_width4   = (r_state == IDLE) ? bus.BITWIDTH4 : r_width4;
    assign w_wr_addr  = bus.BINCYCLENUM[AW-1:0];
    assign w_in_range = (w_wr_addr < AW'(PAGEBITS));
    assign w_wr_en    = w_capturing && !bus.nBINCLKEN && w_in_range;

    // The upper cycle-number bits carry no page address information.
    assign w_unused_cyc_hi = ^bus.BINCYCLENUM[12:AW];

    // Stream order inverts the output-buffer decode: highest channel first within each cycle.
    assign w_rd_cyc   = r_width4 ? r_idx[AW+1:2] : r_idx[AW:1];
    assign w_rd_ch    = r_width4 ? ~r_idx[1:0] : {1'b0, ~r_idx[0]};
    assign w_last_idx = r_width4 ? LAST_IDX_4 : LAST_IDX_2;
    assign w_strobe   = (r_state == DRAIN) && !bus.nINBUFRDCLKEN;

    // NOTE: the page buffer has no reset; contents are only meaningful after a capture,
    // and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge MCLK) begin
        if (w_wr_en) begin
            r_mem[0][w_wr_addr] <= ~bus.DIN0;
            r_mem[1][w_wr_addr] <= ~bus.DIN1;
            if (w_width4) begin
                r_mem[2][w_wr_addr] <= ~bus.DIN2;
                r_mem[3][w_wr_addr] <= ~bus.DIN3;
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state      <= IDLE;
            r_width4     <= 1'b0;
            r_got        <= 1'b0;
            r_idx        <= '0;
            r_rd_data    <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_last    <= 1'b0;
            r_page_valid <= 1'b0;
            r_cap_err    <= 1'b0;
        end else begin
            if ((r_state == READY || r_state == DRAIN) && w_acc_wr) begin
                r_cap_err <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_acc_wr) begin
                        r_state   <= CAPTURE;
                        r_width4  <= bus.BITWIDTH4;
                        r_got     <= w_wr_en;
                        r_cap_err <= 1'b0;
                        r_rd_last <= 1'b0;
                    end
                end

                CAPTURE: begin
                    if (w_wr_en) begin
                        r_got <= 1'b1;
                    end
                    if (!w_acc_wr) begin
                        if (r_got || w_wr_en) begin
                            r_state      <= READY;
                            r_page_valid <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end

                READY: begin
                    if (bus.DRAINSTART) begin
                        r_state <= DRAIN;
                        r_idx   <= '0;
                    end
                end

                DRAIN: begin
                    if (w_strobe) begin
                        r_rd_data <= r_mem[w_rd_ch][w_rd_cyc];
                        r_rd_addr <= r_idx;
                        r_rd_last <= (r_idx == w_last_idx);
                        if (r_idx == w_last_idx) begin
                            r_state      <= IDLE;
                            r_page_valid <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 12'd1;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.INBUFRDDATA = r_rd_data;
    assign bus.INBUFRDADDR = r_rd_addr;
    assign bus.INBUFRDLAST = r_rd_last;
    assign bus.PAGEVALID   = r_page_valid;
    assign bus.CAPERR      = r_cap_err;

endmodule

// File: tb/tb_bubble_in_capture.sv
// Randomized bench for bubble_in_capture against a page-level buffer model.
module tb_bubble_in_capture;

    localparam int PAGEBITS = 584;

    typedef struct {
        logic [12:0] cyc;
        logic [3:0]  pins;
    } tick_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    bubble_in_capture_if bus ();

    bubble_in_capture dut (
        .MCLK   (clk),
        .nRESET (rst_n),
        .bus    (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    bit    model_mem [4][1024];
    bit    model_w4 = 1'b0;
    tick_t tick_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pins(input logic [3:0] p);
        {bus.DIN3, bus.DIN2, bus.DIN1, bus.DIN0} = p;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"}, 32'(bus.INBUFRDDATA), 32'd0);
        check({tag, "_addr"}, 32'(bus.INBUFRDADDR), 32'd0);
        check({tag, "_last"}, 32'(bus.INBUFRDLAST), 32'd0);
        check({tag, "_pv"},   32'(bus.PAGEVALID),   32'd0);
        check({tag, "_err"},  32'(bus.CAPERR),      32'd0);
    endtask

    // Plays tick_q as one write access; overrun means the page is already held.
    task automatic capture(input bit w4, input bit overrun);
        int  in_range = 0;
        bit  first    = 1'b1;
        bus.ACCTYPE   = 3'b101;
        bus.BITWIDTH4 = w4;
        if (tick_q.size() == 0) begin
            step();
            check("cap_start_err", 32'(bus.CAPERR), 32'(overrun));
        end
        foreach (tick_q[i]) begin
            bus.nBINCLKEN   = 1'b0;
            bus.BINCYCLENUM = tick_q[i].cyc;
            set_pins(tick_q[i].pins);
            if (!overrun && tick_q[i].cyc[9:0] < 10'(PAGEBITS)) begin
                in_range++;
                for (int n = 0; n < 4; n++) begin
                    if (n < 2 || w4) model_mem[n][tick_q[i].cyc[9:0]] = ~tick_q[i].pins[n];
                end
            end
            step();
            bus.nBINCLKEN = 1'b1;
            set_pins(4'($urandom));
            if (first) check("cap_start_err", 32'(bus.CAPERR), 32'(overrun));
            first = 1'b0;
            bus.BITWIDTH4 = 1'($urandom);
            repeat ($urandom_range(0, 2)) step();
        end
        if (!overrun) model_w4 = w4;
        repeat (2) step();
        bus.ACCTYPE = 3'b000;
        step();
        check("cap_pv", 32'(bus.PAGEVALID), 32'(overrun || in_range > 0));
        check("cap_err", 32'(bus.CAPERR), 32'(overrun));
    endtask

    // gap < 0 gives random strobe spacing; otherwise one strobe every gap cycles.
    task automatic drain(input int gap, input int abort_at);
        int n   = model_w4 ? 4 : 2;
        int len = PAGEBITS * n;
        bit exp_bit;
        bus.DRAINSTART = 1'b1;
        step();
        bus.DRAINSTART = 1'b0;
        for (int k = 0; k < len; k++) begin
            exp_bit = model_mem[n - 1 - (k % n)][k / n];
            bus.nINBUFRDCLKEN = 1'b0;
            step();
            bus.nINBUFRDCLKEN = 1'b1;
            check("drain_data", 32'(bus.INBUFRDDATA), 32'(exp_bit));
            check("drain_addr", 32'(bus.INBUFRDADDR), 32'(k));
            check("drain_last", 32'(bus.INBUFRDLAST), 32'(k == len - 1));
            if (k == 0 || k == len - 1) check("drain_pv", 32'(bus.PAGEVALID), 32'(k != len - 1));
            if (k == abort_at) return;
            if (gap < 0) begin
                repeat ($urandom_range(0, 3)) step();
            end else begin
                for (int g = 1; g < gap; g++) begin
                    step();
                    check("hold_data", 32'(bus.INBUFRDDATA), 32'(exp_bit));
                    check("hold_addr", 32'(bus.INBUFRDADDR), 32'(k));
                end
            end
        end
    endtask

    task automatic fill_full_page(input int kind);
        tick_q.delete();
        for (int c = 0; c < PAGEBITS; c++) begin
            tick_t t;
            t.cyc = {3'($urandom), 10'(c)};
            case (kind)
                0:       t.pins = {3'b111, ~c[0]};
                1:       t.pins = (c == 5) ? 4'b0101 : 4'b1111;
                default: t.pins = 4'($urandom);
            endcase
            tick_q.push_back(t);
        end
    endtask

    initial begin
        bus.ACCTYPE       = 3'b000;
        bus.BITWIDTH4     = 1'b0;
        bus.BINCYCLENUM   = '0;
        bus.nBINCLKEN     = 1'b1;
        bus.DRAINSTART    = 1'b0;
        bus.nINBUFRDCLKEN = 1'b1;
        set_pins(4'hF);
        repeat (2) step();
        check_outputs_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        step();

        // Basic 2-bit page: stream is 0, c[0] per cycle.
        fill_full_page(0);
        capture(1'b0, 1'b0);
        drain(-1, -1);

        // 4-bit ordering, drained with a strobe every 7th cycle.
        fill_full_page(1);
        capture(1'b1, 1'b0);
        drain(7, -1);

        // Write access with only out-of-range ticks leaves nothing to drain.
        tick_q.delete();
        for (int c = PAGEBITS; c <= 700; c += 29) tick_q.push_back('{13'(c), 4'($urandom)});
        capture(1'b1, 1'b0);
        bus.DRAINSTART = 1'b1;
        step();
        bus.DRAINSTART = 1'b0;
        repeat (3) begin
            bus.nINBUFRDCLKEN = 1'b0;
            step();
        end
        bus.nINBUFRDCLKEN = 1'b1;
        check("empty_addr", 32'(bus.INBUFRDADDR), 32'd2335);
        check("empty_last", 32'(bus.INBUFRDLAST), 32'd0);
        check("empty_pv",   32'(bus.PAGEVALID),   32'd0);

        // Out-of-range ticks plus one in-range tick with high cycle bits set.
        tick_q.delete();
        tick_q.push_back('{13'h1400 | 13'd10, 4'b0000});
        for (int c = PAGEBITS; c <= 700; c += 13) tick_q.push_back('{13'(c) | 13'h0C00, 4'($urandom)});
        capture(1'b1, 1'b0);
        drain(-1, -1);

        // Overrun: second write access while READY must not disturb the held page.
        fill_full_page(2);
        capture(1'b0, 1'b0);
        fill_full_page(2);
        capture(1'b1, 1'b1);
        drain(-1, -1);

        // Reset mid-drain.
        fill_full_page(2);
        capture(1'b1, 1'b0);
        drain(-1, 300);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_drain");
        repeat (2) step();
        @(negedge clk) rst_n = 1'b1;
        step();
        bus.DRAINSTART = 1'b1;
        step();
        bus.DRAINSTART = 1'b0;
        repeat (4) begin
            bus.nINBUFRDCLKEN = 1'b0;
            step();
        end
        bus.nINBUFRDCLKEN = 1'b1;
        step();
        check_outputs_zero("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
